stamp_capture_arbiter: RTL and testbench

//  Shares the free-running timestamp counter between NUM_PORTS capture requesters (per-port RX/TX SOF pulses).

---
 rtl/stamp_cap_pkg.sv | 16 +
 rtl/stamp_capture_arbiter_rr_arbiter.sv | 35 +++
 rtl/stamp_capture_arbiter.sv | 122 ++++++++++++
 tb/tb_stamp_capture_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/stamp_cap_pkg.sv
// Shared defaults and types for the timestamp capture arbiter.
package stamp_cap_pkg;

  localparam int DEF_NUM_PORTS   = 4;
  localparam int DEF_TS_W        = 64;
  localparam int DEF_PORT_ID_W   = 2;
  localparam int DEF_DROP_CNT_W  = 16;

  localparam logic [DEF_DROP_CNT_W-1:0] DEF_DROP_SAT = '1;

  typedef struct packed {
    logic [DEF_PORT_ID_W-1:0] port;
    logic [DEF_TS_W-1:0]      stamp;
  } cap_word_t;

endpackage

// File: rtl/stamp_capture_arbiter_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr_i, cyclically.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  input  logic                 advance_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PTR_W-1:0]     gnt_idx_o,
  output logic                 any_gnt_o
);

  always_comb begin : search
    int idx;
    logic [PTR_W-1:0] idx_w;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    idx       = 0;
    idx_w     = '0;
    if (advance_i) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx   = (int'(ptr_i) + k) % NUM_PORTS;
        idx_w = PTR_W'(idx);
        if (!any_gnt_o && req_i[idx_w]) begin
          gnt_o[idx_w] = 1'b1;
          gnt_idx_o    = idx_w;
          any_gnt_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stamp_capture_arbiter.sv
// Latches the shared timestamp per requesting port and serialises the stamps
// round-robin onto one valid/ready capture stream with saturating drop counters.
module stamp_capture_arbiter
  import stamp_cap_pkg::*;
#(
  parameter int NUM_PORTS       = DEF_NUM_PORTS,
  parameter int TIMESTAMP_WIDTH = DEF_TS_W,
  parameter int PORT_ID_WIDTH   = DEF_PORT_ID_W,
  parameter int DROP_CNT_WIDTH  = DEF_DROP_CNT_W
) (
  input  logic                                axi_aclk,
  input  logic                                axi_reset,
  input  logic [TIMESTAMP_WIDTH-1:0]          stamp_counter,
  input  logic                                enable,
  input  logic [NUM_PORTS-1:0]                req,
  output logic                                cap_valid,
  input  logic                                cap_ready,
  output logic [TIMESTAMP_WIDTH-1:0]          cap_stamp,
  output logic [PORT_ID_WIDTH-1:0]            cap_port,
  input  logic                                clear_drops,
  output logic [NUM_PORTS*DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_SAT = '1;

  logic [NUM_PORTS-1:0]       pending_q, pending_d;
  logic [TIMESTAMP_WIDTH-1:0] hold_q [NUM_PORTS];
  logic [TIMESTAMP_WIDTH-1:0] hold_d [NUM_PORTS];
  logic [DROP_CNT_WIDTH-1:0]  drop_q [NUM_PORTS];
  logic [DROP_CNT_WIDTH-1:0]  drop_d [NUM_PORTS];
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic                       cap_valid_q, cap_valid_d;
  logic [TIMESTAMP_WIDTH-1:0] cap_stamp_q, cap_stamp_d;
  logic [PORT_ID_WIDTH-1:0]   cap_port_q, cap_port_d;

  logic                 advance;
  logic [NUM_PORTS-1:0] gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 any_gnt;

  assign advance = !cap_valid_q || cap_ready;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req_i     (pending_q),
    .ptr_i     (rr_ptr_q),
    .advance_i (advance),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  // A slot granted this cycle is free to reload, so a port pulsing every cycle never drops.
  always_comb begin : slot_next
    logic live, accept;
    live   = 1'b0;
    accept = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      live         = req[i] && enable;
      accept       = live && (!pending_q[i] || gnt[i]);
      pending_d[i] = accept ? 1'b1 : (gnt[i] ? 1'b0 : pending_q[i]);
      hold_d[i]    = accept ? stamp_counter : hold_q[i];
      if (clear_drops)
        drop_d[i] = '0;
      else if (live && !accept && drop_q[i] != DROP_SAT)
        drop_d[i] = drop_q[i] + DROP_CNT_WIDTH'(1);
      else
        drop_d[i] = drop_q[i];
    end
  end

  always_comb begin : out_next
    cap_valid_d = cap_valid_q;
    cap_stamp_d = cap_stamp_q;
    cap_port_d  = cap_port_q;
    rr_ptr_d    = rr_ptr_q;
    if (advance) begin
      if (any_gnt) begin
        cap_valid_d = 1'b1;
        cap_stamp_d = hold_q[gnt_idx];
        cap_port_d  = PORT_ID_WIDTH'(gnt_idx);
        rr_ptr_d    = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end else begin
        cap_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      pending_q   <= '0;
      hold_q      <= '{default: '0};
      drop_q      <= '{default: '0};
      rr_ptr_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_stamp_q <= '0;
      cap_port_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      hold_q      <= hold_d;
      drop_q      <= drop_d;
      rr_ptr_q    <= rr_ptr_d;
      cap_valid_q <= cap_valid_d;
      cap_stamp_q <= cap_stamp_d;
      cap_port_q  <= cap_port_d;
    end
  end

  assign cap_valid = cap_valid_q;
  assign cap_stamp = cap_stamp_q;
  assign cap_port  = cap_port_q;

  always_comb begin : drop_pack
    drop_cnt = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      drop_cnt[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_q[i];
  end

endmodule

// File: tb/tb_stamp_capture_arbiter.sv
// Directed bench for stamp_capture_arbiter with hand-computed expected words and counters.
module tb_stamp_capture_arbiter;
  import stamp_cap_pkg::*;

  localparam int NP = 4;
  localparam int TW = 64;
  localparam int PW = 2;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [TW-1:0]     stamp_counter;
  logic              enable;
  logic [NP-1:0]     req;
  logic              cap_valid;
  logic              cap_ready;
  logic [TW-1:0]     cap_stamp;
  logic [PW-1:0]     cap_port;
  logic              clear_drops;
  logic [NP*DW-1:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stamp_capture_arbiter #(
    .NUM_PORTS       (NP),
    .TIMESTAMP_WIDTH (TW),
    .PORT_ID_WIDTH   (PW),
    .DROP_CNT_WIDTH  (DW)
  ) dut (
    .axi_aclk      (clk),
    .axi_reset     (rst),
    .stamp_counter (stamp_counter),
    .enable        (enable),
    .req           (req),
    .cap_valid     (cap_valid),
    .cap_ready     (cap_ready),
    .cap_stamp     (cap_stamp),
    .cap_port      (cap_port),
    .clear_drops   (clear_drops),
    .drop_cnt      (drop_cnt)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] drops(input int p);
    return drop_cnt[p*DW +: DW];
  endfunction

  task automatic chk_word(input string tag, input logic [PW-1:0] p, input logic [TW-1:0] s);
    cap_word_t got_w, exp_w;
    got_w.port  = cap_port;
    got_w.stamp = cap_stamp;
    exp_w.port  = p;
    exp_w.stamp = s;
    chk({tag, "_valid"}, 80'(cap_valid), 80'(1'b1));
    chk({tag, "_word"}, 80'(got_w), 80'(exp_w));
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 80'(cap_valid), 80'(1'b0));
  endtask

  initial begin
    rst = 1'b1; stamp_counter = '0; enable = 1'b0; req = '0;
    cap_ready = 1'b0; clear_drops = 1'b0;
    step(); step();
    chk("rst_valid", 80'(cap_valid), 80'(0));
    chk("rst_stamp", 80'(cap_stamp), 80'(0));
    chk("rst_port",  80'(cap_port),  80'(0));
    chk("rst_drops", 80'(drop_cnt),  80'(0));
    rst = 1'b0; enable = 1'b1; cap_ready = 1'b1;
    step();

    // Single request on port 2
    req = 4'b0100; stamp_counter = 64'h100; step();
    req = '0; stamp_counter = 64'h101;
    chk_idle("t1_lat1");
    step(); chk_word("t1", 2'd2, 64'h100);
    step(); chk_idle("t1_once");

    // All ports at once, pointer restarted by reset
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; stamp_counter = 64'h200; step();
    req = '0;
    for (int p = 0; p < NP; p++) begin
      step(); chk_word($sformatf("t2_p%0d", p), PW'(p), 64'h200);
    end
    step(); chk_idle("t2_end");
    req = 4'b1010; stamp_counter = 64'h210; step();
    req = '0;
    step(); chk_word("t2_ptr0_a", 2'd1, 64'h210);
    step(); chk_word("t2_ptr0_b", 2'd3, 64'h210);
    step(); chk_idle("t2_ptr0_end");

    // Backpressure: first word held, slot keeps second stamp, third dropped
    cap_ready = 1'b0;
    req = 4'b0010; stamp_counter = 64'h10; step();
    req = '0; step();
    req = 4'b0010; stamp_counter = 64'h20; step();
    stamp_counter = 64'h30; step();
    req = '0;
    chk_word("t3_hold", 2'd1, 64'h10);
    chk("t3_drop1", 80'(drops(1)), 80'(1));
    step(); step();
    chk_word("t3_stable", 2'd1, 64'h10);
    cap_ready = 1'b1;
    step(); chk_word("t3_second", 2'd1, 64'h20);
    step(); chk_idle("t3_end");

    // Port 3 ahead of a continuous port 0 stream
    req = 4'b1000; stamp_counter = 64'h300; step();
    for (int k = 1; k <= 6; k++) begin
      req = 4'b0001; stamp_counter = 64'h300 + 64'(k); step();
      if (k == 1) chk_word("t4_p3", 2'd3, 64'h300);
      else        chk_word($sformatf("t4_p0_%0d", k), 2'd0, 64'h300 + 64'(k - 1));
    end
    req = '0;
    step(); chk_word("t4_last", 2'd0, 64'h306);
    step(); chk_idle("t4_end");
    chk("t4_nodrop0", 80'(drops(0)), 80'(0));

    // Saturation, clear priority, disabled requests
    cap_ready = 1'b0;
    req = 4'b0001; stamp_counter = 64'h500; step();
    req = '0; step();
    req = 4'b0001; stamp_counter = 64'h501; step();
    stamp_counter = 64'h5FF;
    repeat (65541) step();
    req = '0;
    chk("t5_sat", 80'(drops(0)), 80'(16'hFFFF));
    chk("t5_drop1_kept", 80'(drops(1)), 80'(1));
    chk_word("t5_held", 2'd0, 64'h500);
    req = 4'b0001; clear_drops = 1'b1; step();
    req = '0; clear_drops = 1'b0;
    chk("t5_clr0", 80'(drops(0)), 80'(0));
    chk("t5_clr1", 80'(drops(1)), 80'(0));
    req = 4'b0001; step();
    req = '0;
    chk("t5_after_clr", 80'(drops(0)), 80'(1));
    enable = 1'b0;
    req = 4'b0100; stamp_counter = 64'h700; step();
    req = '0; cap_ready = 1'b1;
    step(); chk_word("t5_drain", 2'd0, 64'h501);
    step(); chk_idle("t5_no_dis_word");
    chk("t5_no_dis_drop", 80'(drops(2)), 80'(0));
    enable = 1'b1;

    // Reset with three slots pending and a word on the output
    cap_ready = 1'b0;
    req = 4'b0001; stamp_counter = 64'h5F0; step();
    req = '0; step();
    req = 4'b1110; stamp_counter = 64'h600; step();
    req = '0;
    chk_word("t6_pre", 2'd0, 64'h5F0);
    rst = 1'b1; step();
    chk("t6_valid", 80'(cap_valid), 80'(0));
    chk("t6_stamp", 80'(cap_stamp), 80'(0));
    chk("t6_port",  80'(cap_port),  80'(0));
    chk("t6_drops", 80'(drop_cnt),  80'(0));
    rst = 1'b0; cap_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_idle($sformatf("t6_stale_%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
